// File: rtl/img_filter_pkg.sv
// Shared constants and types for the streaming 3x3 Gaussian image filter.
// Kernel is [1 2 1; 2 4 2; 1 2 1], normalised by a right shift of KERNEL_SHIFT.
package img_filter_pkg;

  localparam int DATA_W       = 8;
  localparam int IMG_W        = 16;
  localparam int IMG_H        = 16;
  localparam int SUM_GUARD    = 4;
  localparam int SUM_W        = DATA_W + SUM_GUARD;

  localparam int K_CORNER     = 1;
  localparam int K_EDGE       = 2;
  localparam int K_CENTRE     = 4;
  localparam int KERNEL_SHIFT = 4;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef pixel_t [2:0][2:0] window_t;

endpackage

// File: rtl/img_line_buffer.sv
// One image line of storage: asynchronous read, synchronous write at the same index,
// so a read in the writing cycle returns the previous line's pixel.
module img_line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  import img_filter_pkg::*;

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // store the incoming pixel over the one just read out
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/rtl_top_img_filter.sv
// Streaming 3x3 Gaussian filter core: raster counters, two line buffers, 3x3 window,
// registered adder tree output. Valid convolution only; latency two cycles after accept.
module rtl_top_img_filter #(
  parameter int DATA_W = img_filter_pkg::DATA_W,
  parameter int IMG_W  = img_filter_pkg::IMG_W,
  parameter int IMG_H  = img_filter_pkg::IMG_H
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_x,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_y,
  output logic              o_last
);
  import img_filter_pkg::*;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int ACC_W = DATA_W + SUM_GUARD;

  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [DATA_W-1:0] lb1_rd_s;
  logic [DATA_W-1:0] lb2_rd_s;
  // [row][col]: row 0 is line r-2, row 2 the current line; col 2 is the newest column
  logic [DATA_W-1:0] win_r [3][3];
  logic              win_valid_r;
  logic              win_last_r;
  logic [ACC_W-1:0]  sum_s;
  logic              col_wrap_s;
  logic              row_wrap_s;
  logic              emit_s;
  logic              last_s;

  img_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk   (clk),
    .en    (i_valid),
    .addr  (col_r),
    .wdata (i_x),
    .rdata (lb1_rd_s)
  );

  img_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb2 (
    .clk   (clk),
    .en    (i_valid),
    .addr  (col_r),
    .wdata (lb1_rd_s),
    .rdata (lb2_rd_s)
  );

  // position decode for the pixel presented this cycle
  always_comb begin
    col_wrap_s = 1'b0;
    row_wrap_s = 1'b0;
    emit_s     = 1'b0;
    last_s     = 1'b0;
    col_wrap_s = (col_r == COL_W'(IMG_W - 1));
    row_wrap_s = (row_r == ROW_W'(IMG_H - 1));
    if (i_valid) begin
      emit_s = (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));
      last_s = col_wrap_s && row_wrap_s;
    end else begin
      emit_s = 1'b0;
      last_s = 1'b0;
    end
  end

  // raster column/row counters, frozen on idle cycles
  always_ff @(posedge clk) begin
    if (rstn) begin
      col_r <= COL_W'(0);
      row_r <= ROW_W'(0);
    end else if (i_valid) begin
      if (col_wrap_s) begin
        col_r <= COL_W'(0);
        row_r <= row_wrap_s ? ROW_W'(0) : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // shift a new column into the window on every accepted pixel
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= {DATA_W{1'b0}};
        end
      end
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
    end else begin
      if (i_valid) begin
        for (int i = 0; i < 3; i++) begin
          win_r[i][0] <= win_r[i][1];
          win_r[i][1] <= win_r[i][2];
        end
        win_r[0][2] <= lb2_rd_s;
        win_r[1][2] <= lb1_rd_s;
        win_r[2][2] <= i_x;
      end
      win_valid_r <= emit_s;
      win_last_r  <= last_s;
    end
  end

  // weighted sum; 16 * max pixel fits in ACC_W so no overflow
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    sum_s = ACC_W'(win_r[0][0]) * ACC_W'(K_CORNER) + ACC_W'(win_r[0][1]) * ACC_W'(K_EDGE)
          + ACC_W'(win_r[0][2]) * ACC_W'(K_CORNER) + ACC_W'(win_r[1][0]) * ACC_W'(K_EDGE)
          + ACC_W'(win_r[1][1]) * ACC_W'(K_CENTRE) + ACC_W'(win_r[1][2]) * ACC_W'(K_EDGE)
          + ACC_W'(win_r[2][0]) * ACC_W'(K_CORNER) + ACC_W'(win_r[2][1]) * ACC_W'(K_EDGE)
          + ACC_W'(win_r[2][2]) * ACC_W'(K_CORNER);
  end

  // output register stage; o_y holds its last value between valid outputs
  always_ff @(posedge clk) begin
    if (rstn) begin
      o_valid <= 1'b0;
      o_y     <= {DATA_W{1'b0}};
      o_last  <= 1'b0;
    end else begin
      o_valid <= win_valid_r;
      o_last  <= win_last_r;
      if (win_valid_r) begin
        o_y <= DATA_W'(sum_s >> KERNEL_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_rtl_top_img_filter.sv
// Self-checking bench: frame-image reference model predicts every output and its cycle;
// a negedge compare process checks the DUT, and literal checks pin the model.
module tb_rtl_top_img_filter;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int M_CONST   = 0;
  localparam int M_IMPULSE = 1;
  localparam int M_RAMP    = 2;
  localparam int M_RANDOM  = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_valid;
  logic [DATA_W-1:0] i_x;
  logic              o_valid;
  logic [DATA_W-1:0] o_y;
  logic              o_last;

  rtl_top_img_filter #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_x     (i_x),
    .o_valid (o_valid),
    .o_y     (o_y),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int y;
    bit last;
    int cr;
    int cc;
  } exp_t;

  exp_t exp_q[$];
  int   img [IMG_H][IMG_W];
  int   out_img [IMG_H][IMG_W];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pix_idx = 0;
  int   out_cnt = 0;
  int   last_cnt = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: store the pixel into a frame image and, for interior positions,
  // convolve the 3x3 neighbourhood centred one row up and one column left.
  always @(posedge clk) begin
    int r, c, acc;
    exp_t e;
    cyc = cyc + 1;
    if (rstn === 1'b1) begin
      exp_q.delete();
      pix_idx = 0;
    end else if (i_valid === 1'b1) begin
      r = pix_idx / IMG_W;
      c = pix_idx % IMG_W;
      img[r][c] = int'(i_x);
      if (r >= 2 && c >= 2) begin
        acc = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            acc += img[r - 1 + dr][c - 1 + dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
          end
        end
        e.due  = cyc + 1;
        e.y    = acc / 16;
        e.last = (r == IMG_H - 1) && (c == IMG_W - 1);
        e.cr   = r - 1;
        e.cc   = c - 1;
        exp_q.push_back(e);
      end
      pix_idx = (pix_idx + 1) % (IMG_W * IMG_H);
    end
  end

  // Compare process: an output is required exactly when the model scheduled one.
  always @(negedge clk) begin
    if (chk_en) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("missed_output", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("o_valid_exp", {31'd0, o_valid}, 32'd1);
        check("o_y", {24'd0, o_y}, exp_q[0].y);
        check("o_last", {31'd0, o_last}, {31'd0, exp_q[0].last});
        if (o_valid === 1'b1) begin
          out_img[exp_q[0].cr][exp_q[0].cc] = int'(o_y);
          out_cnt++;
          if (o_last === 1'b1) last_cnt++;
        end
        void'(exp_q.pop_front());
      end else begin
        check("o_valid_idle", {31'd0, o_valid}, 32'd0);
        check("o_last_idle", {31'd0, o_last}, 32'd0);
        if (o_valid === 1'b1) out_cnt++;
      end
    end
  end

  function automatic int pix_val(input int mode, input int v, input int r, input int c);
    case (mode)
      M_CONST:   return v;
      M_IMPULSE: return (r == 5 && c == 5) ? v : 0;
      M_RAMP:    return c;
      default:   return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic drive_idle(input int n);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b0;
      i_x     = DATA_W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
  endtask

  // gap: 0 = none, 1 = alternate pixel/idle, 2 = random 0..2 idle cycles
  task automatic send_frame(input int mode, input int v, input int gap, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        i_valid = 1'b1;
        i_x     = DATA_W'(pix_val(mode, v, r, c));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        if (gap == 1) drive_idle(1);
        if (gap == 2) drive_idle(int'($urandom_range(0, 2)));
      end
    end
  endtask

  task automatic start_frame_stats();
    out_cnt  = 0;
    last_cnt = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        out_img[r][c] = -1;
  endtask

  task automatic end_frame_stats(input string name, input int n_out, input int n_last);
    drive_idle(4);
    check({name, "_count"}, out_cnt, n_out);
    check({name, "_lasts"}, last_cnt, n_last);
  endtask

  task automatic pulse_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  initial begin
    rstn    = 1'b1;
    i_valid = 1'b0;
    i_x     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o_valid", {31'd0, o_valid}, 32'd0);
    check("reset_o_y", {24'd0, o_y}, 32'd0);
    check("reset_o_last", {31'd0, o_last}, 32'd0);
    rstn   = 1'b0;
    chk_en = 1'b1;
    drive_idle(2);

    start_frame_stats();
    send_frame(M_CONST, 24, 0, IMG_H);
    end_frame_stats("const24", 196, 1);
    check("const24_tl", out_img[1][1], 24);
    check("const24_br", out_img[14][14], 24);

    start_frame_stats();
    send_frame(M_IMPULSE, 160, 0, IMG_H);
    end_frame_stats("impulse", 196, 1);
    check("imp_centre", out_img[5][5], 40);
    check("imp_up", out_img[4][5], 20);
    check("imp_left", out_img[5][4], 20);
    check("imp_right", out_img[5][6], 20);
    check("imp_down", out_img[6][5], 20);
    check("imp_diag_ul", out_img[4][4], 10);
    check("imp_diag_dr", out_img[6][6], 10);
    check("imp_far", out_img[8][8], 0);

    start_frame_stats();
    send_frame(M_CONST, 255, 0, IMG_H);
    end_frame_stats("const255", 196, 1);
    check("const255_val", out_img[7][9], 255);

    start_frame_stats();
    send_frame(M_CONST, 1, 0, IMG_H);
    end_frame_stats("const1", 196, 1);
    check("const1_val", out_img[3][3], 1);

    start_frame_stats();
    send_frame(M_RAMP, 0, 0, IMG_H);
    end_frame_stats("ramp", 196, 1);
    check("ramp_c7", out_img[3][7], 7);
    check("ramp_c13", out_img[10][13], 13);
    check("ramp_c1", out_img[12][1], 1);

    start_frame_stats();
    send_frame(M_CONST, 24, 1, IMG_H);
    end_frame_stats("gapped", 196, 1);
    check("gapped_val", out_img[6][2], 24);

    send_frame(M_RANDOM, 0, 0, 7);
    send_frame(M_RANDOM, 0, 0, 1);
    pulse_reset();
    start_frame_stats();
    drive_idle(3);
    check("post_reset_none", out_cnt, 0);
    send_frame(M_CONST, 24, 0, IMG_H);
    end_frame_stats("after_reset", 196, 1);
    check("after_reset_val", out_img[2][2], 24);

    start_frame_stats();
    send_frame(M_CONST, 24, 0, IMG_H);
    send_frame(M_CONST, 100, 0, IMG_H);
    end_frame_stats("b2b", 392, 2);
    check("b2b_second", out_img[1][1], 100);

    for (int f = 0; f < 3; f++) begin
      start_frame_stats();
      send_frame(M_RANDOM, 0, (f == 0) ? 0 : 2, IMG_H);
      end_frame_stats("random", 196, 1);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtl_top_img_filter.md
Name: rtl_top_img_filter

Overview:
Single-clock streaming 3x3 Gaussian image filter, the datapath core of the image-filter top level. It accepts one raster-order pixel per valid cycle on i_x and applies kernel [1 2 1; 2 4 2; 1 2 1]/16 using two line buffers. It emits one filtered pixel for every interior pixel position (valid convolution, no border padding).

Parameters:
DATA_W, 8, pixel width in bits (unsigned)
IMG_W, 16, pixels per line (>=3)
IMG_H, 16, lines per frame (>=3)

Ports:
clk  in  1  system clock, all logic rising-edge
rstn  in  1  reset, synchronous, active-high despite the n suffix (codebase naming kept)
i_valid  in  1  i_x carries a pixel this cycle
i_x  in  DATA_W  input pixel, raster order, row-major
o_valid  out  1  o_y valid this cycle
o_y  out  DATA_W  filtered pixel
o_last  out  1  with o_valid, marks last output pixel of frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rstn=1 at posedge): o_valid=0, o_y=0, o_last=0, column/row counters=0, window registers=0. Line-buffer contents need not be cleared.
- Counters:
  - col advances 0..IMG_W-1 on each accepted pixel.
  - row advances 0..IMG_H-1 when col wraps.
  - After the pixel at (IMG_H-1, IMG_W-1), both counters return to 0; the next pixel starts a new frame.
- No backpressure. i_valid may deassert any cycle; idle cycles freeze all state, and o_valid=0 on the corresponding output cycle.
- Line buffers: two IMG_W-deep buffers hold rows r-1 and r-2, written and read at index col on each accepted pixel. A 3x3 window shift register of three columns is shifted on each accepted pixel.
- Output condition: accepted pixel at (r,c) with r>=2 and c>=2 produces the result centred at (r-1,c-1). Otherwise no output. Outputs per frame = (IMG_H-2)*(IMG_W-2).
- Latency: o_valid asserts exactly 2 clk after the accepting cycle, via a registered window plus a registered sum stage. This latency is constant regardless of idle gaps.
- Arithmetic:
  - Sum is unsigned with width DATA_W+4 and cannot overflow.
  - o_y = sum>>4, truncating. The result fits in DATA_W.
- o_last=1 with the output whose source pixel is (IMG_H-1, IMG_W-1).
- Reset mid-frame: pipeline is flushed with no output for in-flight pixels. The next accepted pixel is treated as (0,0).
- Windows never straddle a line wrap. At c<2 the window holds a previous-row tail but no output is produced.

Decomposition:
- Package img_filter_pkg:
  - DATA_W, IMG_W, IMG_H defaults.
  - SUM_W = DATA_W+4.
  - Kernel weight constants.
  - typedef pixel_t.
  - typedef window_t (3x3 pixel_t).
- Sub-module img_line_buffer: single-port read-before-write RAM of IMG_W x DATA_W, instantiated twice.
- The top holds the counters, window, adder tree and output registers.

Test Plan:
- Constant frame: every pixel i_x=24 for a full 16x16 frame with i_valid=1 -> 196 outputs, all o_y=24. o_last only on the 196th. First o_valid 2 cycles after pixel (2,2).
- Impulse: zeros except 160 at (5,5) -> output at centre (5,5)=40; edge-adjacent centres (4,5),(6,5),(5,4),(5,6)=20; diagonal centres=10; all others 0.
- Truncation: constant 255 gives 255; constant 1 gives 1. Horizontal ramp i_x=col gives o_y=c for centre column c.
- Gapped input: constant-24 frame with i_valid toggling 1,0 -> same 196 values, each o_valid exactly 2 cycles after its source pixel, and o_valid=0 on gap-derived cycles.
- Reset mid-frame: assert rstn at row 7 -> no further o_valid from old pixels. A following complete constant-24 frame yields exactly 196 outputs of 24.
- Back-to-back frames: two constant frames, 24 then 100, without gaps -> 196 outputs of 24, then 196 outputs of 100, with no cross-frame mixing and two o_last pulses.
